alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- ALU reservation station feeding the issue stage: buffers dispatched ALU micro-ops and captures source operands from the common data bus (CDB).
- Selects the oldest entry with both operands ready and drives the packed 67-bit alu_data word plus its ROB tag to the issue stage through a valid/ready output register.
- Producer side of the alu_data packing {ctrl[2:0], src2[31:0], src1[31:0]}.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, ROB tag width (alu_rob_num, operand tags).
- DATA_W, 32, operand width; alu_data width is 2*DATA_W+3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch this cycle.
- disp_ctrl  in  3  ALU op code.
- disp_rob_num  in  TAG_W  ROB tag of the op.
- disp_src1_rdy / disp_src2_rdy  in  1  operand value already valid.
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when not ready.
- disp_src1_val / disp_src2_val  in  DATA_W  operand value when ready.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB producer tag.
- cdb_data  in  DATA_W  CDB result.
- alu_ready  in  1  ALU accepts the issued op.
- alu_iss  out  1  issued op valid.
- alu_data  out  2*DATA_W+3  {ctrl, src2, src1}.
- alu_rob_num  out  TAG_W  ROB tag of the issued op.

Behaviour:
- Reset (rst_n low, asynchronous): all entry valid bits 0, count 0, alu_iss 0, alu_data 0, alu_rob_num 0. disp_ready is 1 once out of reset.
- Collapsing queue: slot 0 is the oldest entry.
  - Dispatch appends at slot count minus the number removed this cycle.
  - Issue removes the selected slot; younger slots shift down one position in the same edge.
- disp_ready = (count != DEPTH). It is combinational from registered count, with no same-cycle issue credit. disp_valid while !disp_ready is ignored with no side effects.
- Wakeup:
  - For every valid entry and every operand with rdy=0 and tag==cdb_tag while cdb_valid: capture cdb_data and set rdy=1 at the edge.
  - A dispatching op with a matching tag in the same cycle also captures (dispatch bypass).
  - No duplicate-tag checking is performed.
- Select: the lowest-index valid entry with both rdy=1, evaluated on registered state. Wakeup and select do not interact within one cycle.
- Output register:
  - Loads when alu_iss==0 or alu_ready==1.
  - If a ready entry exists: alu_iss<=1, alu_data<={ctrl,src2,src1}, alu_rob_num<=tag, and the entry is removed. Otherwise alu_iss<=0.
  - While alu_iss && !alu_ready, alu_data and alu_rob_num hold stable and no entry is removed.
- Latency:
  - Dispatch with both operands ready into an empty queue at cycle N gives alu_iss=1 in cycle N+2 (entry written at end of N, selected in N+1).
  - CDB wakeup in cycle N gives the earliest issue at N+2.
  - Sustained throughput is 1 op/cycle.
- Flush: at the edge, clears all entries, count, and alu_iss. A dispatch or CDB capture in the flush cycle is dropped. disp_ready is 1 in the next cycle.
- Simultaneous dispatch, wakeup, and issue in one cycle are all legal and independent, except that the issued slot's removal is applied before the append position is computed.
- count never exceeds DEPTH and never underflows. Assertions: a dispatch is never accepted when count==DEPTH, and the ordering of valid entries is preserved.

Decomposition:
- Package issue_pkg:
  - Constants: ALU_DATA_W=67, ALU_CTRL_LSB=64, ALU_SRC2_LSB=32, TAG_W=6.
  - Typedef alu_rs_entry_t: valid, ctrl, rob_num, and per-operand rdy, tag, val.
  - Helper function pack_alu_data(ctrl, src2, src1).
- One sub-module, rs_oldest_ready_sel: a DEPTH-wide priority picker producing the one-hot grant and index of the lowest set bit of (valid & rdy1 & rdy2).

Test Plan:
- Reset, then dispatch ctrl=3'b010, rob=5, src1=32'h10, src2=32'h20 (both ready), alu_ready=1 → two cycles later alu_iss=1, alu_data={3'b010,32'h20,32'h10}, alu_rob_num=5; alu_iss=0 in the following cycle.
- Dispatch rob=7 with src2 waiting on tag 9; CDB tag 9, data 32'hDEAD three cycles later → issue two cycles after the broadcast with src2=32'hDEAD. Also repeat with the CDB in the same cycle as dispatch → captured, issued at N+2.
- Fill 4 entries all waiting on tag 1, hold alu_ready=0 → disp_ready=0 and a 5th dispatch is ignored. Broadcast tag 1 → alu_data holds rob0's word until alu_ready rises, then issue order is rob0..rob3 on consecutive cycles.
- Dispatch rob=1 (waiting tag 4), then rob=2 (ready) → rob=2 issues first; rob=1 issues after the tag 4 broadcast (oldest-ready, not strict FIFO).
- Three entries are valid and alu_iss=1 when flush is pulsed together with disp_valid → next cycle alu_iss=0, count=0, disp_ready=1, no issue follows.
- Assert rst_n low asynchronously mid-clock with the queue full → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the ALU reservation station.
// Entry layout and the alu_data word packing live here.
package issue_pkg;

    localparam int TAG_W        = 6;
    localparam int DATA_W       = 32;
    localparam int ALU_DATA_W   = 67;
    localparam int ALU_CTRL_LSB = 64;
    localparam int ALU_SRC2_LSB = 32;

    typedef struct packed {
        logic              valid;
        logic [2:0]        ctrl;
        logic [TAG_W-1:0]  rob_num;
        logic              rdy1;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] val1;
        logic              rdy2;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val2;
    } alu_rs_entry_t;

    function automatic logic [ALU_DATA_W-1:0] pack_alu_data(
        input logic [2:0]        ctrl,
        input logic [DATA_W-1:0] src2,
        input logic [DATA_W-1:0] src1
    );
        logic [ALU_DATA_W-1:0] w;
        w = '0;
        w[ALU_CTRL_LSB +: 3]      = ctrl;
        w[ALU_SRC2_LSB +: DATA_W] = src2;
        w[0 +: DATA_W]            = src1;
        return w;
    endfunction

endpackage

// File: rtl/rs_oldest_ready_sel.sv
// Priority picker: one-hot grant and index of the lowest set request.
// Slot 0 is the oldest entry, so lowest index means oldest ready.
module rs_oldest_ready_sel #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !any_o) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU reservation station with CDB wakeup and
// oldest-ready select into a valid/ready output register.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [2:0]            disp_ctrl,
    input  logic [TAG_W-1:0]      disp_rob_num,
    input  logic                  disp_src1_rdy,
    input  logic                  disp_src2_rdy,
    input  logic [TAG_W-1:0]      disp_src1_tag,
    input  logic [TAG_W-1:0]      disp_src2_tag,
    input  logic [DATA_W-1:0]     disp_src1_val,
    input  logic [DATA_W-1:0]     disp_src2_val,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [DATA_W-1:0]     cdb_data,
    input  logic                  alu_ready,
    output logic                  alu_iss,
    output logic [2*DATA_W+2:0]   alu_data,
    output logic [TAG_W-1:0]      alu_rob_num
);
    import issue_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    alu_rs_entry_t ent_q [DEPTH];
    alu_rs_entry_t ent_w [DEPTH];
    alu_rs_entry_t ent_s [DEPTH];
    alu_rs_entry_t ent_d [DEPTH];
    alu_rs_entry_t new_e;
    alu_rs_entry_t sel_e;

    logic [CNT_W-1:0]    count_q, count_d, cnt_rm;
    logic                iss_q, iss_d;
    logic [2*DATA_W+2:0] data_q, data_d;
    logic [TAG_W-1:0]    rob_q, rob_d;

    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] sel_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             full, disp_acc, load, do_iss;
    logic             order_ok;

    function automatic alu_rs_entry_t wake(
        input alu_rs_entry_t     e,
        input logic              v,
        input logic [TAG_W-1:0]  t,
        input logic [DATA_W-1:0] d
    );
        alu_rs_entry_t r;
        r = e;
        if (e.valid && v && !e.rdy1 && e.tag1 == t) begin
            r.rdy1 = 1'b1;
            r.val1 = d;
        end
        if (e.valid && v && !e.rdy2 && e.tag2 == t) begin
            r.rdy2 = 1'b1;
            r.val2 = d;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
        end
    end

    rs_oldest_ready_sel #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .req_i (rdy_vec),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    always_comb begin
        sel_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_gnt[i]) sel_e = ent_q[i];
        end
    end

    assign full       = (count_q == CNT_W'(DEPTH));
    assign disp_ready = !full;
    assign disp_acc   = disp_valid && !full;
    assign load       = !iss_q || alu_ready;
    assign do_iss     = load && sel_any;

    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.ctrl    = disp_ctrl;
        new_e.rob_num = disp_rob_num;
        new_e.rdy1    = disp_src1_rdy;
        new_e.tag1    = disp_src1_tag;
        new_e.val1    = disp_src1_val;
        new_e.rdy2    = disp_src2_rdy;
        new_e.tag2    = disp_src2_tag;
        new_e.val2    = disp_src2_val;
        new_e         = wake(new_e, cdb_valid, cdb_tag, cdb_data);
    end

    // Wakeup first, then collapse over the issued slot, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_iss && i >= int'(sel_idx)) ent_s[i] = ent_w[i+1];
            else                              ent_s[i] = ent_w[i];
        end
        if (do_iss) ent_s[DEPTH-1] = '0;
        else        ent_s[DEPTH-1] = ent_w[DEPTH-1];

        cnt_rm  = count_q - CNT_W'(do_iss);
        count_d = cnt_rm + CNT_W'(disp_acc);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_s[i];
            if (disp_acc && cnt_rm == CNT_W'(i)) ent_d[i] = new_e;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_comb begin
        iss_d  = iss_q;
        data_d = data_q;
        rob_d  = rob_q;
        if (flush) begin
            iss_d = 1'b0;
        end else if (load) begin
            iss_d = sel_any;
            if (sel_any) begin
                data_d = pack_alu_data(sel_e.ctrl, sel_e.val2, sel_e.val1);
                rob_d  = sel_e.rob_num;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
            iss_q   <= 1'b0;
            data_q  <= '0;
            rob_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
            iss_q   <= iss_d;
            data_q  <= data_d;
            rob_q   <= rob_d;
        end
    end

    assign alu_iss     = iss_q;
    assign alu_data    = data_q;
    assign alu_rob_num = rob_q;

    // Valid entries must be packed into slots [0, count).
    always_comb begin
        order_ok = (count_q <= CNT_W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid != (CNT_W'(i) < count_q)) order_ok = 1'b0;
        end
    end

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        full |-> !disp_acc);
    a_order: assert property (@(posedge clk) disable iff (!rst_n)
        order_ok);

endmodule
